ddr_native_wr_buffer: RTL
=========================

Name: ddr_native_wr_buffer

Overview:
- Write-side staging buffer that sits directly upstream of the DDR3 controller's native write port.
- Accepts write beats (address, data, byte mask) from a ready/valid client and queues them in a FIFO.
- Replays each beat to the controller, holding it stable until acknowledged and respecting controller backpressure.
- Decouples traffic sources (memory checker, DMA) from controller busy periods and calibration stalls.

Parameters:
- DATA_W, 128, write data width; equals the controller write FIFO width.
- MASK_W, 16, byte-mask width; equals DATA_W/8.
- ADDR_W, 32, native address width.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ACK_TIMEOUT, 1023, cycles in ISSUE without wr_ack before timeout_err is set.

Ports:
- clk  in  1  single clock, shared with the controller native port.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  client beat valid.
- s_ready  out  1  buffer can accept a beat.
- s_addr  in  ADDR_W  client beat address.
- s_data  in  DATA_W  client beat data.
- s_mask  in  MASK_W  client byte mask; 1 = byte masked.
- wr_busy  in  1  controller busy; no new beat may be launched while high.
- wr_ack  in  1  controller accepted the presented beat.
- wr_en  out  1  beat presented to the controller.
- wr_addr_en  out  1  identical copy of wr_en.
- wr_addr  out  ADDR_W  presented address.
- wr_data  out  DATA_W  presented data.
- wr_datamask  out  MASK_W  presented mask.
- fill_level  out  log2(DEPTH)+1  current FIFO occupancy.
- idle  out  1  FIFO empty and no beat outstanding.
- timeout_err  out  1  sticky: ack timeout occurred.

Behaviour:
- Reset values: s_ready=0 while reset is asserted and 1 after release; wr_en=wr_addr_en=0; wr_addr/wr_data/wr_datamask=0; fill_level=0; idle=1; timeout_err=0; state=IDLE.
- Client handshake:
  - A beat transfers when s_valid && s_ready.
  - s_ready = (fill_level != DEPTH), computed from registered count only.
  - At full, a pop in the same cycle does not open s_ready.
- FIFO: push and pop in the same cycle leave the count unchanged; pointers wrap modulo DEPTH.
- State IDLE: if FIFO non-empty && !wr_busy, pop the head into the output registers, set wr_en=1 and go to ISSUE.
- State ISSUE:
  - Outputs are held stable until wr_ack.
  - On wr_ack, if FIFO non-empty && !wr_busy: pop the next beat in the same cycle and stay in ISSUE (back-to-back; wr_en stays 1).
  - On wr_ack otherwise: wr_en=0 and go to IDLE.
- Latency: beat accepted at cycle N (FIFO previously empty, wr_busy=0) -> wr_en=1 at cycle N+2.
- Sustained throughput: 1 beat/cycle when wr_ack is returned every cycle.
- wr_ack while in IDLE is ignored.
- wr_busy rising while in ISSUE does not withdraw the presented beat; it only blocks the next launch.
- Timeout:
  - The counter increments each ISSUE cycle without wr_ack and clears on wr_ack.
  - At ACK_TIMEOUT, timeout_err sets (sticky until reset).
  - The beat is never dropped; the block keeps waiting.
- idle = (fill_level==0) && (state==IDLE).
- Reset mid-operation: the outstanding beat and queued beats are discarded; all outputs return to reset values asynchronously.

Optional Feature:
- Macro WR_BUF_STATS_EN.
- Defined: adds outputs stat_beats (32 bits; beats acknowledged, saturating at all-ones) and stat_max_fill (log2(DEPTH)+1 bits; high-water mark of fill_level). Both are cleared by reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package ddr_wr_buf_pkg: state encoding (IDLE=0, ISSUE=1), default widths (DATA_W/MASK_W/ADDR_W), and a count-width function clog2.
- Sub-module ddr_wr_sfifo: synchronous FIFO storing {addr, mask, data}, with push/pop/full/empty/count ports, parameterised width and depth.
- The FSM, output registers and timeout counter stay in the top level.

Test Plan:
- Single beat: reset, then push addr=0x100, data=0xA5..A5, mask=0, with wr_busy=0 and wr_ack one cycle after wr_en -> wr_en high at accept+2 with exact payload; idle returns to 1 after ack.
- Back-to-back: push 16 beats and tie wr_ack=wr_en -> 16 consecutive wr_en cycles, addresses in order, no gaps.
- Full: DEPTH=16, wr_busy=1, push 20 beats -> s_ready falls after 16 with fill_level=16; releasing wr_busy drains all 16 beats in order.
- Backpressure hold: wr_busy=1 during ISSUE and wr_ack delayed 5 cycles -> payload stable for all 5 cycles; next beat launches only after wr_busy=0.
- Timeout: wr_ack never asserted, ACK_TIMEOUT=1023 -> timeout_err=1 exactly 1023 ISSUE cycles after wr_en; wr_en stays 1; a later wr_ack completes the beat and timeout_err remains 1.
- Reset mid-burst: assert reset with 8 beats queued and 1 outstanding -> wr_en=0, fill_level=0, idle=1 immediately; with WR_BUF_STATS_EN, stat_beats=0.

Source files
------------

// File: rtl/ddr_wr_buf_pkg.sv
// Shared types and helpers for the DDR native-port write buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr_wr_buf_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_MASK_W = 16;
    localparam int DEF_ADDR_W = 32;

    // Launch FSM: IDLE waits for a beat, ISSUE presents one to the controller.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wr_state_e;

    // Ceiling log2, usable in constant expressions for port widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_wr_sfifo.sv
// Synchronous FIFO holding {addr, mask, data} write beats; head is read combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; count is registered.
module ddr_wr_sfifo
    import ddr_wr_buf_pkg::*;
#(
    parameter  int WIDTH = DEF_ADDR_W + DEF_MASK_W + DEF_DATA_W,
    parameter  int DEPTH = 16,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array: data path only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; push+pop keeps count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_native_wr_buffer.sv
// Write staging buffer feeding the DDR controller native write port; optional stats via WR_BUF_STATS_EN.
// Latency: beat accepted in cycle N reaches wr_en in cycle N+2; 1 beat/cycle with continuous wr_ack.
// Backpressure: s_ready drops when the FIFO is full; wr_busy blocks launches, never withdraws a presented beat.
module ddr_native_wr_buffer
    import ddr_wr_buf_pkg::*;
#(
    parameter  int DATA_W      = DEF_DATA_W,
    parameter  int MASK_W      = DEF_MASK_W,
    parameter  int ADDR_W      = DEF_ADDR_W,
    parameter  int DEPTH       = 16,
    parameter  int ACK_TIMEOUT = 1023,
    localparam int CNT_W       = clog2(DEPTH) + 1,
    localparam int TMO_W       = clog2(ACK_TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_data,
    input  logic [MASK_W-1:0] s_mask,
    input  logic              wr_busy,
    input  logic              wr_ack,
    output logic              wr_en,
    output logic              wr_addr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [MASK_W-1:0] wr_datamask,
    output logic [CNT_W-1:0]  fill_level,
    output logic              idle,
    output logic              timeout_err
`ifdef WR_BUF_STATS_EN
    ,
    output logic [31:0]       stat_beats,
    output logic [CNT_W-1:0]  stat_max_fill
`endif
);

    localparam int          ENT_W   = ADDR_W + MASK_W + DATA_W;
    localparam [TMO_W-1:0]  TMO_MAX = TMO_W'(ACK_TIMEOUT);
    localparam [TMO_W-1:0]  TMO_PRE = TMO_W'(ACK_TIMEOUT - 1);

    wr_state_e          state;
    wr_state_e          state_nxt;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENT_W-1:0]   head;
    logic [TMO_W-1:0]   tmo_cnt;

    // s_ready comes only from the registered count, so a same-cycle pop at full does not open it.
    assign s_ready = !reset && !fifo_full;

    ddr_wr_sfifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (s_valid && s_ready),
        .push_data ({s_addr, s_mask, s_data}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fill_level)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Launch decision: pop a beat when idle or when the current one is acked, unless busy/empty.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !wr_busy) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_ack) begin
                    if (!fifo_empty && !wr_busy) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_en      = (state == ISSUE);
    assign wr_addr_en = wr_en;
    assign idle       = (fill_level == '0) && (state == IDLE);

    // Output payload registers: load only on a launch so the beat holds until acked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr     <= '0;
            wr_datamask <= '0;
            wr_data     <= '0;
        end else if (pop) begin
            {wr_addr, wr_datamask, wr_data} <= head;
        end
    end

    // Ack watchdog: counts unacknowledged ISSUE cycles; the error flag is sticky and the beat is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else if (wr_ack) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_cnt == TMO_PRE) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef WR_BUF_STATS_EN
    // Acknowledged-beat counter (saturating) and FIFO high-water mark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_beats    <= '0;
            stat_max_fill <= '0;
        end else begin
            if ((state == ISSUE) && wr_ack && (stat_beats != '1)) begin
                stat_beats <= stat_beats + 1'b1;
            end
            if (fill_level > stat_max_fill) begin
                stat_max_fill <= fill_level;
            end
        end
    end
`endif

endmodule
